spike_decoder: RTL

Receive-side companion to the Hodgkin-Huxley neuron core: it consumes the neuron's spike output and decodes it into numeric activity measures. It reports a firing-rate count per programmable observation window and the inter-spike interval (ISI) between consecutive spikes. Results are presented as registered values with single-cycle valid strobes, so the wrapper or a host readout can sample them.

---
 rtl/spike_decoder_if.sv | 24 ++
 rtl/spike_decoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/spike_decoder_if.sv
// Bus bundle between the neuron-side driver and the spike decoder.
// master drives spike level and run control; slave returns the decoded measures.
interface spike_decoder_if #(
   parameter int WINDOW_W = 16,
   parameter int ISI_W    = 16
);
   logic                spike_in;
   logic                enable;
   logic [WINDOW_W-1:0] window_len;
   logic [7:0]          rate_out;
   logic                rate_valid;
   logic [ISI_W-1:0]    isi_out;
   logic                isi_valid;

   modport master (
      output spike_in, enable, window_len,
      input  rate_out, rate_valid, isi_out, isi_valid
   );

   modport slave (
      input  spike_in, enable, window_len,
      output rate_out, rate_valid, isi_out, isi_valid
   );
endinterface

// File: rtl/spike_decoder.sv
// Decodes a neuron spike level into a per-window firing count and the
// inter-spike interval, each presented as a registered value with a one-cycle strobe.
module spike_decoder #(
   parameter int WINDOW_W = 16,
   parameter int ISI_W    = 16
) (
   input  logic            clk,
   input  logic            rst,
   spike_decoder_if.slave  bus
);
   typedef enum logic {W_IDLE = 1'b0, W_RUN = 1'b1} win_state_t;
   typedef enum logic {I_NOREF = 1'b0, I_HAVEREF = 1'b1} isi_state_t;

   localparam logic [WINDOW_W-1:0] WIN_ONE = {{(WINDOW_W-1){1'b0}}, 1'b1};
   localparam logic [ISI_W-1:0]    ISI_ONE = {{(ISI_W-1){1'b0}}, 1'b1};
   localparam logic [ISI_W-1:0]    ISI_MAX = {ISI_W{1'b1}};

   win_state_t          win_q, win_d;
   isi_state_t          isi_st_q, isi_st_d;
   logic                spk_q, spk_d;
   logic [WINDOW_W-1:0] len_q, len_d, cyc_q, cyc_d, len_eff_s;
   logic [7:0]          cnt_q, cnt_d, rate_q, rate_d;
   logic                rate_vld_q, rate_vld_d;
   logic [ISI_W-1:0]    icnt_q, icnt_d, isi_q, isi_d;
   logic                isi_vld_q, isi_vld_d;
   logic                ev_s;

   function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic inc);
      if (inc && (v != 8'hFF)) begin
         return v + 8'd1;
      end else begin
         return v;
      end
   endfunction

   function automatic logic [ISI_W-1:0] sat_inc_isi(input logic [ISI_W-1:0] v);
      if (v != ISI_MAX) begin
         return v + ISI_ONE;
      end else begin
         return v;
      end
   endfunction

   // Next-state logic for edge detect, window counter and ISI tracker.
   always_comb begin
      spk_d      = bus.spike_in;
      win_d      = win_q;
      isi_st_d   = isi_st_q;
      len_d      = len_q;
      cyc_d      = cyc_q;
      cnt_d      = cnt_q;
      rate_d     = rate_q;
      rate_vld_d = 1'b0;
      icnt_d     = icnt_q;
      isi_d      = isi_q;
      isi_vld_d  = 1'b0;
      ev_s       = bus.spike_in & ~spk_q;
      len_eff_s  = (bus.window_len == '0) ? WIN_ONE : bus.window_len;

      case (win_q)
         W_IDLE: begin
            cyc_d = '0;
            cnt_d = 8'd0;
            if (bus.enable) begin
               win_d = W_RUN;
               len_d = len_eff_s;
            end else begin
               win_d = W_IDLE;
            end
         end
         W_RUN: begin
            if (!bus.enable) begin
               win_d = W_IDLE;
               cyc_d = '0;
               cnt_d = 8'd0;
            end else if ((cyc_q + WIN_ONE) == len_q) begin
               // closing edge: an event here still belongs to this window
               rate_d     = sat_add8(cnt_q, ev_s);
               rate_vld_d = 1'b1;
               cyc_d      = '0;
               cnt_d      = 8'd0;
               len_d      = len_eff_s;
            end else begin
               cyc_d = cyc_q + WIN_ONE;
               cnt_d = sat_add8(cnt_q, ev_s);
            end
         end
         default: begin
            win_d = W_IDLE;
         end
      endcase

      case (isi_st_q)
         I_NOREF: begin
            icnt_d = '0;
            if (bus.enable && ev_s) begin
               isi_st_d = I_HAVEREF;
            end else begin
               isi_st_d = I_NOREF;
            end
         end
         I_HAVEREF: begin
            if (!bus.enable) begin
               isi_st_d = I_NOREF;
               icnt_d   = '0;
            end else if (ev_s) begin
               isi_d     = sat_inc_isi(icnt_q);
               isi_vld_d = 1'b1;
               icnt_d    = '0;
            end else begin
               icnt_d = sat_inc_isi(icnt_q);
            end
         end
         default: begin
            isi_st_d = I_NOREF;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q      <= W_IDLE;
         isi_st_q   <= I_NOREF;
         spk_q      <= 1'b0;
         len_q      <= WIN_ONE;
         cyc_q      <= '0;
         cnt_q      <= 8'd0;
         rate_q     <= 8'd0;
         rate_vld_q <= 1'b0;
         icnt_q     <= '0;
         isi_q      <= '0;
         isi_vld_q  <= 1'b0;
      end else begin
         win_q      <= win_d;
         isi_st_q   <= isi_st_d;
         spk_q      <= spk_d;
         len_q      <= len_d;
         cyc_q      <= cyc_d;
         cnt_q      <= cnt_d;
         rate_q     <= rate_d;
         rate_vld_q <= rate_vld_d;
         icnt_q     <= icnt_d;
         isi_q      <= isi_d;
         isi_vld_q  <= isi_vld_d;
      end
   end

   assign bus.rate_out   = rate_q;
   assign bus.rate_valid = rate_vld_q;
   assign bus.isi_out    = isi_q;
   assign bus.isi_valid  = isi_vld_q;
endmodule
